// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads the instruction ROM and
// registers one 24-bit word per cycle toward the dependency check block.
// Loads are issued twice, JMP redirects with no penalty, CJMP parks the
// unit in BR_WAIT until execute resolves it, and HALT stops fetch until reset.
module instruction_fetch_unit #(
    parameter int unsigned         PC_W     = 8,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter logic [23:0]         NOP_WORD = 24'h000000
) (
    input  logic            clk,
    input  logic            reset,       // asynchronous, active low
    output logic [PC_W-1:0] im_addr,
    input  logic [23:0]     im_data,
    input  logic            cond_valid,
    input  logic            cond_taken,
    output logic [23:0]     ins,
    output logic [PC_W-1:0] pc,
    output logic            br_wait,
    output logic            halted
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LD_REPEAT = 2'd1,
        BR_WAIT   = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;
    localparam logic [4:0] OP_LD   = 5'b10100;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] br_target_q, br_target_d;
    logic [23:0]     ins_q, ins_d;
    logic            br_wait_q, br_wait_d;
    logic            halted_q, halted_d;

    logic [4:0]      op;
    logic            is_jmp, is_halt, is_cjmp, is_ld;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] word_target;

    // Decode the class of the word currently presented by the ROM.
    always_comb begin
        op          = im_data[23:19];
        is_jmp      = (op == OP_JMP);
        is_halt     = (op == OP_HALT);
        is_cjmp     = (op[4:2] == 3'b111);
        is_ld       = (op == OP_LD);
        // Increment wraps modulo 2^PC_W naturally through the fixed width.
        pc_inc      = pc_q + PC_W'(1);
        word_target = PC_W'(im_data[7:0]);
    end

    // Next-state, next-PC and next-instruction selection.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; a missing default in always_comb infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        br_target_d = br_target_q;
        ins_d       = ins_q;

        unique case (state_q)
            RUN: begin
                ins_d = im_data;
                if (is_jmp) begin
                    pc_d = word_target;
                end else if (is_halt) begin
                    state_d = HALTED;
                end else if (is_cjmp) begin
                    br_target_d = word_target;
                    state_d     = BR_WAIT;
                end else if (is_ld) begin
                    state_d = LD_REPEAT;
                end else begin
                    pc_d = pc_inc;
                end
            end
            LD_REPEAT: begin
                // Second copy of the LD word; the decoder turns it into a bubble.
                ins_d   = im_data;
                pc_d    = pc_inc;
                state_d = RUN;
            end
            BR_WAIT: begin
                ins_d = NOP_WORD;
                if (cond_valid) begin
                    pc_d    = cond_taken ? br_target_q : pc_inc;
                    state_d = RUN;
                end
            end
            HALTED: begin
                ins_d = NOP_WORD;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Status flags are registered so they line up with the NOPs on ins.
        br_wait_d = (state_q == BR_WAIT);
        halted_d  = (state_q == HALTED);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            br_target_q <= '0;
            ins_q       <= NOP_WORD;
            br_wait_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from values sampled before the edge.
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_target_q <= br_target_d;
            ins_q       <= ins_d;
            br_wait_q   <= br_wait_d;
            halted_q    <= halted_d;
        end
    end

    assign im_addr = pc_q;
    assign pc      = pc_q;
    assign ins     = ins_q;
    assign br_wait = br_wait_q;
    assign halted  = halted_q;

endmodule
